mp_fifo_enq_arbiter: RTL and testbench
======================================

Name: mp_fifo_enq_arbiter

Overview:
- Shares the ENQ_WIDTH enqueue lanes of one multi-port FIFO among NUM_REQ single-lane requesters, e.g. L1D miss, writeback and prefetch sources.
- Each cycle it packs up to "usable lanes" granted requests contiguously from lane 0.
- Priority is round-robin, with a per-requester starvation boost.
- Grant logic is combinational. The round-robin pointer and wait counters are sequential.

Parameters:
- payload_t, logic[3:0], request payload type; identical to the FIFO's payload type.
- NUM_REQ, 4, number of requesters; must be >= 2.
- ENQ_WIDTH, 2, FIFO enqueue lanes; must be >= 1.
- STARVE_LIMIT, 8, consecutive ungranted valid cycles after which a requester is boosted; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- req_vld_i  input  NUM_REQ  request valid per requester
- req_payload_i  input  payload_t[NUM_REQ]  request payload
- req_rdy_o  output  NUM_REQ  grant; handshake completes when req_vld_i & req_rdy_o
- fifo_enq_vld_o  output  ENQ_WIDTH  FIFO enqueue valid
- fifo_enq_payload_o  output  payload_t[ENQ_WIDTH]  FIFO enqueue payload
- fifo_enq_rdy_i  input  ENQ_WIDTH  FIFO enqueue ready
- flush_i  input  1  synchronous flush
- starve_o  output  NUM_REQ  registered; requester currently boosted

Behaviour:
- **Usable lanes.** L = number of leading ones of fifo_enq_rdy_i, counted from lane 0. A non-prefix pattern such as 2'b10 gives L=0.
- **Priority order.**
  - Rotated index pos(r) = (r - rr_ptr) mod NUM_REQ.
  - Candidates are requesters with req_vld_i=1.
  - Boosted candidates (starve[r]=1) come first, in ascending pos.
  - Non-boosted candidates follow, in ascending pos.
  - The first min(L, #candidates) in this order are granted.
- **Lane packing.**
  - The k-th granted requester drives lane k: fifo_enq_vld_o[k]=1, fifo_enq_payload_o[k]=its payload.
  - Lanes >= the grant count have vld=0 and payload don't-care.
  - Order within lanes follows priority order, so two grants in one cycle are enqueued in that order.
- **Requester grant.** req_rdy_o[r]=1 only if r is granted; never 1 while req_vld_i[r]=0. Because of the vld→rdy combinational path, requesters must not derive vld from rdy.
- **Latency.** Zero cycles from request to FIFO enqueue; no internal storage of payloads.
- **rr_ptr update** (clog2(NUM_REQ) bits, reset 0).
  - If any grant: rr_ptr <= (g+1) mod NUM_REQ, where g is the granted requester with the largest pos.
  - Otherwise rr_ptr holds.
- **wait_cnt[r]** (clog2(STARVE_LIMIT+1) bits, reset 0).
  - req_vld_i[r] & !req_rdy_o[r]: saturating increment.
  - Otherwise: cleared to 0.
- **Starvation.** starve[r] = (wait_cnt[r] >= STARVE_LIMIT); starve_o is a direct register read.
- **Flush.**
  - Same cycle: req_rdy_o=0 and fifo_enq_vld_o=0.
  - Next edge: rr_ptr <= 0 and all wait_cnt <= 0.
  - flush_i overrides grants.
- **Reset.**
  - While rst=0, rr_ptr=0, wait_cnt=0 and starve_o=0.
  - req_rdy_o and fifo_enq_vld_o are forced to 0.
  - Reset deassertion mid-traffic takes effect with no partial state.
- **Boundaries.**
  - L=0: no grants; valid requesters' counters increment.
  - L >= #candidates: all candidates granted.
  - Simultaneous boost of several requesters: resolved by pos.
  - rr_ptr wraps NUM_REQ-1 → 0.
  - If NUM_REQ is not a power of 2, the modulo is explicit (no natural wrap).

Decomposition:
- **Shared package (mp_fifo_arb_pkg).**
  - Localparams for pointer width and counter width.
  - A function to rotate a NUM_REQ vector by rr_ptr.
  - A function for the leading-ones count.
- **Sub-module rr_multi_picker** (combinational).
  - Inputs: request vector, boost vector, rr_ptr, L.
  - Outputs: grant vector, per-lane one-hot select, and the last-granted index.
  - Instanced once.
- **Top level** holds the rr_ptr and wait_cnt registers and the lane payload mux.

Test Plan:
- **RR packing.** NUM_REQ=4, ENQ_WIDTH=2, rr_ptr=0, req_vld=4'b1111, rdy=2'b11 → grant 0,1 (lanes 0,1); next cycle grant 2,3; then 0,1; rr_ptr sequence 0→2→0.
- **Partial lanes.** req_vld=4'b1010, rdy=2'b01, rr_ptr=0 → only requester 1 granted on lane 0, rr_ptr=2. Next cycle rdy=2'b10 (non-prefix) → no grant, wait_cnt[3]=1.
- **Starvation.** STARVE_LIMIT=3, rdy=2'b01, requesters 0 and 2 always valid, rr_ptr forced so 0 loses 3 cycles → starve_o[0]=1, and 0 is granted next cycle regardless of rr_ptr; its wait_cnt then returns to 0.
- **Flush.** Requests pending with wait_cnt[1]=2, rr_ptr=3, flush_i=1 → req_rdy_o=0 and fifo_enq_vld_o=0 that cycle; next cycle rr_ptr=0 and wait_cnt all 0.
- **Async reset.** rst driven 0 mid-cycle with grants active → req_rdy_o, fifo_enq_vld_o and starve_o go 0 immediately. After release, the first grant starts from requester 0.
- **End-to-end.** Connected to a 16-deep FIFO (prefix ready), random traffic plus checker: every fired request appears exactly once in the FIFO, and per-requester order is preserved.

Source files
------------

// File: rtl/mp_fifo_arb_pkg.sv
// Shared sizing helpers and vector utilities for the multi-port FIFO enqueue arbiter.
package mp_fifo_arb_pkg;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_ENQ_WIDTH    = 2;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

    // Widest requester/lane vector the helper functions operate on.
    localparam int unsigned MAX_VEC   = 32;
    localparam int unsigned VEC_IDX_W = 5;

    typedef logic [MAX_VEC-1:0] vec_t;

    // Bits needed for a round-robin pointer over n requesters.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    // Bits needed to hold any value in 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return unsigned'($clog2(n + 1));
    endfunction

    // Requester order -> priority order: out[p] = v[(p + ptr) mod n].
    function automatic vec_t rotate_to_pos(input vec_t v, input int unsigned ptr, input int unsigned n);
        vec_t        o;
        int unsigned s;
        o = '0;
        for (int unsigned p = 0; p < n; p++) begin
            s = p + ptr;
            if (s >= n) s = s - n;
            o[VEC_IDX_W'(p)] = v[VEC_IDX_W'(s)];
        end
        return o;
    endfunction

    // Priority order -> requester order: out[(p + ptr) mod n] = v[p].
    function automatic vec_t rotate_from_pos(input vec_t v, input int unsigned ptr, input int unsigned n);
        vec_t        o;
        int unsigned s;
        o = '0;
        for (int unsigned p = 0; p < n; p++) begin
            s = p + ptr;
            if (s >= n) s = s - n;
            o[VEC_IDX_W'(s)] = v[VEC_IDX_W'(p)];
        end
        return o;
    endfunction

    // Length of the unbroken run of ones starting at bit 0.
    function automatic int unsigned leading_ones(input vec_t v, input int unsigned n);
        int unsigned cnt;
        logic        stop;
        cnt  = 0;
        stop = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (!stop && v[VEC_IDX_W'(i)]) cnt = cnt + 1;
            else                            stop = 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_multi_picker.sv
// Combinational multi-grant picker: boosted requesters first, then round-robin,
// packing up to i_lanes grants onto lanes in priority order.
module rr_multi_picker
    import mp_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ENQ_WIDTH = DEF_ENQ_WIDTH,
    parameter int unsigned PTR_W = ptr_width(DEF_NUM_REQ),
    parameter int unsigned LCNT_W = cnt_width(DEF_ENQ_WIDTH)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_boost,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    input  logic [LCNT_W-1:0]  i_lanes,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [NUM_REQ-1:0] o_lane_sel [ENQ_WIDTH],
    output logic [PTR_W-1:0]   o_last_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_req_pos;
    logic [NUM_REQ-1:0] w_boost_pos;
    logic [NUM_REQ-1:0] w_grant_pos;
    logic [NUM_REQ-1:0] w_lane_pos [ENQ_WIDTH];
    int unsigned        w_used;
    int unsigned        w_last_pos;
    int unsigned        w_last_sum;

    // Two passes over priority order: boosted candidates, then the rest.
    always_comb begin
        w_req_pos   = NUM_REQ'(rotate_to_pos(MAX_VEC'(i_req), 32'(i_rr_ptr), NUM_REQ));
        w_boost_pos = NUM_REQ'(rotate_to_pos(MAX_VEC'(i_boost), 32'(i_rr_ptr), NUM_REQ));
        w_grant_pos = '0;
        for (int unsigned k = 0; k < ENQ_WIDTH; k++) w_lane_pos[k] = '0;
        w_used      = 0;
        w_last_pos  = 0;
        w_last_sum  = 0;

        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned p = 0; p < NUM_REQ; p++) begin
                if (w_req_pos[p] && (w_boost_pos[p] == (pass == 0)) && (w_used < 32'(i_lanes))) begin
                    w_grant_pos[p] = 1'b1;
                    for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
                        if (k == w_used) w_lane_pos[k][p] = 1'b1;
                    end
                    w_used = w_used + 1;
                end
            end
        end

        // Pointer advances past the grant furthest along the rotation, not the last lane.
        for (int unsigned p = 0; p < NUM_REQ; p++) begin
            if (w_grant_pos[p]) w_last_pos = p;
        end
        w_last_sum = w_last_pos + 32'(i_rr_ptr);
        if (w_last_sum >= NUM_REQ) w_last_sum = w_last_sum - NUM_REQ;
    end

    always_comb begin
        o_grant = NUM_REQ'(rotate_from_pos(MAX_VEC'(w_grant_pos), 32'(i_rr_ptr), NUM_REQ));
        for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
            o_lane_sel[k] = NUM_REQ'(rotate_from_pos(MAX_VEC'(w_lane_pos[k]), 32'(i_rr_ptr), NUM_REQ));
        end
        o_last_idx = PTR_W'(w_last_sum);
        o_any      = |w_grant_pos;
    end

endmodule

// File: rtl/mp_fifo_enq_arbiter.sv
// Shares the enqueue lanes of a multi-port FIFO among single-lane requesters with
// round-robin priority and a per-requester starvation boost; zero-latency pass-through.
module mp_fifo_enq_arbiter
    import mp_fifo_arb_pkg::*;
#(
    parameter type         payload_t    = logic [3:0],
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned ENQ_WIDTH    = DEF_ENQ_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld_i,
    input  payload_t             req_payload_i [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_rdy_o,
    output logic [ENQ_WIDTH-1:0] fifo_enq_vld_o,
    output payload_t             fifo_enq_payload_o [ENQ_WIDTH],
    input  logic [ENQ_WIDTH-1:0] fifo_enq_rdy_i,
    input  logic                 flush_i,
    output logic [NUM_REQ-1:0]   starve_o
);

    localparam int unsigned PTR_W  = ptr_width(NUM_REQ);
    localparam int unsigned CNT_W  = cnt_width(STARVE_LIMIT);
    localparam int unsigned LCNT_W = cnt_width(ENQ_WIDTH);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] r_starve;

    logic [LCNT_W-1:0]  w_lanes;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_lane_sel [ENQ_WIDTH];
    logic [PTR_W-1:0]   w_last_idx;
    logic               w_any;
    logic               w_active;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt [NUM_REQ];

    assign w_lanes  = LCNT_W'(leading_ones(MAX_VEC'(fifo_enq_rdy_i), ENQ_WIDTH));
    assign w_active = rst & ~flush_i;

    rr_multi_picker #(
        .NUM_REQ   (NUM_REQ),
        .ENQ_WIDTH (ENQ_WIDTH),
        .PTR_W     (PTR_W),
        .LCNT_W    (LCNT_W)
    ) u_picker (
        .i_req      (req_vld_i),
        .i_boost    (r_starve),
        .i_rr_ptr   (r_rr_ptr),
        .i_lanes    (w_lanes),
        .o_grant    (w_grant),
        .o_lane_sel (w_lane_sel),
        .o_last_idx (w_last_idx),
        .o_any      (w_any)
    );

    // Reset and flush both suppress every handshake in the current cycle.
    assign req_rdy_o = w_grant & {NUM_REQ{w_active}};

    always_comb begin
        for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
            fifo_enq_vld_o[k]     = w_active & (|w_lane_sel[k]);
            fifo_enq_payload_o[k] = '0;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (w_lane_sel[k][r]) fifo_enq_payload_o[k] = req_payload_i[r];
            end
        end
    end

    // Explicit wrap keeps non-power-of-two requester counts correct.
    assign w_ptr_nxt = (w_last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_last_idx + PTR_W'(1);

    always_comb begin
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            w_cnt_nxt[r] = '0;
            if (req_vld_i[r] && !req_rdy_o[r]) begin
                w_cnt_nxt[r] = r_wait_cnt[r];
                if (r_wait_cnt[r] < CNT_W'(STARVE_LIMIT)) w_cnt_nxt[r] = r_wait_cnt[r] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_starve <= '0;
            for (int unsigned r = 0; r < NUM_REQ; r++) r_wait_cnt[r] <= '0;
        end else if (flush_i) begin
            r_rr_ptr <= '0;
            r_starve <= '0;
            for (int unsigned r = 0; r < NUM_REQ; r++) r_wait_cnt[r] <= '0;
        end else begin
            if (w_any) r_rr_ptr <= w_ptr_nxt;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                r_wait_cnt[r] <= w_cnt_nxt[r];
                r_starve[r]   <= (w_cnt_nxt[r] >= CNT_W'(STARVE_LIMIT));
            end
        end
    end

    assign starve_o = r_starve;

endmodule

// File: tb/tb_mp_fifo_enq_arbiter.sv
// Directed bench for mp_fifo_enq_arbiter (4 requesters, 2 lanes, starvation limit 3).
module tb_mp_fifo_enq_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_vld;
    logic [3:0] req_payload [4];
    logic [3:0] req_rdy;
    logic [1:0] enq_vld;
    logic [3:0] enq_payload [2];
    logic [1:0] enq_rdy;
    logic       flush;
    logic [3:0] starve;

    int n_cmp;
    int n_err;

    mp_fifo_enq_arbiter #(
        .payload_t    (logic [3:0]),
        .NUM_REQ      (4),
        .ENQ_WIDTH    (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_vld_i          (req_vld),
        .req_payload_i      (req_payload),
        .req_rdy_o          (req_rdy),
        .fifo_enq_vld_o     (enq_vld),
        .fifo_enq_payload_o (enq_payload),
        .fifo_enq_rdy_i     (enq_rdy),
        .flush_i            (flush),
        .starve_o           (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    // Grant vector, lane valids and the payload of every expected-valid lane.
    task automatic chk_out(input string tag, input logic [3:0] e_rdy, input logic [1:0] e_vld,
                           input logic [3:0] e_p0, input logic [3:0] e_p1);
        chk({tag, " req_rdy"}, 32'(req_rdy), 32'(e_rdy));
        chk({tag, " enq_vld"}, 32'(enq_vld), 32'(e_vld));
        if (e_vld[0]) chk({tag, " lane0"}, 32'(enq_payload[0]), 32'(e_p0));
        if (e_vld[1]) chk({tag, " lane1"}, 32'(enq_payload[1]), 32'(e_p1));
    endtask

    task automatic drive(input logic [3:0] v, input logic [1:0] r, input logic f);
        @(negedge clk);
        req_vld = v;
        enq_rdy = r;
        flush   = f;
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        req_vld = 4'b0;
        enq_rdy = 2'b0;
        flush   = 1'b0;
        for (int r = 0; r < 4; r++) req_payload[r] = 4'(r + 9);

        // In reset: outputs forced low despite full demand
        drive(4'b1111, 2'b11, 1'b0);
        chk_out("R0", 4'b0000, 2'b00, 4'h0, 4'h0);
        chk("R0 starve", 32'(starve), 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 4'b0;

        // Round-robin packing, pointer 0 -> 2 -> 0 (wrap) -> 2 -> 0
        drive(4'b1111, 2'b11, 1'b0); chk_out("A1", 4'b0011, 2'b11, 4'h9, 4'hA);
        drive(4'b1111, 2'b11, 1'b0); chk_out("A2", 4'b1100, 2'b11, 4'hB, 4'hC);
        drive(4'b1111, 2'b11, 1'b0); chk_out("A3", 4'b0011, 2'b11, 4'h9, 4'hA);
        drive(4'b1111, 2'b11, 1'b0); chk_out("A4", 4'b1100, 2'b11, 4'hB, 4'hC);

        // Partial lanes, then non-prefix ready gives no lanes
        drive(4'b1010, 2'b01, 1'b0); chk_out("B1", 4'b0010, 2'b01, 4'hA, 4'h0);
        drive(4'b1010, 2'b10, 1'b0); chk_out("B2", 4'b0000, 2'b00, 4'h0, 4'h0);
        drive(4'b1010, 2'b10, 1'b0); chk_out("B3", 4'b0000, 2'b00, 4'h0, 4'h0);
        chk("B3 starve", 32'(starve), 32'h0);

        // Requester 3 boosted outranks requester 2 at rotated position 0
        drive(4'b1110, 2'b01, 1'b0);
        chk("B4 starve", 32'(starve), 32'h8);
        chk_out("B4", 4'b1000, 2'b01, 4'hC, 4'h0);

        // Requester 1 boosted outranks requester 0 at rotated position 0
        drive(4'b0011, 2'b01, 1'b0);
        chk("B5 starve", 32'(starve), 32'h2);
        chk_out("B5", 4'b0010, 2'b01, 4'hA, 4'h0);

        // Flush with pointer at 2: nothing granted, then pointer back at 0
        drive(4'b1111, 2'b11, 1'b1); chk_out("F1", 4'b0000, 2'b00, 4'h0, 4'h0);
        drive(4'b1111, 2'b01, 1'b0);
        chk("F2 starve", 32'(starve), 32'h0);
        chk_out("F2", 4'b0001, 2'b01, 4'h9, 4'h0);

        // Requesters 0 and 2 starve together; order resolved by rotated position
        drive(4'b0101, 2'b00, 1'b0); chk_out("S1", 4'b0000, 2'b00, 4'h0, 4'h0);
        drive(4'b0101, 2'b00, 1'b0);
        drive(4'b0101, 2'b00, 1'b0);
        chk("S3 starve", 32'(starve), 32'h4);
        drive(4'b0101, 2'b11, 1'b0);
        chk("S4 starve", 32'(starve), 32'h5);
        chk_out("S4", 4'b0101, 2'b11, 4'hB, 4'h9);

        // Build a boost on requester 3 before the asynchronous reset
        drive(4'b1000, 2'b00, 1'b0);
        chk("P1 starve", 32'(starve), 32'h0);
        drive(4'b1000, 2'b00, 1'b0);
        drive(4'b1000, 2'b00, 1'b0);
        drive(4'b1111, 2'b11, 1'b0);
        chk("R1 starve", 32'(starve), 32'h8);
        chk_out("R1", 4'b1010, 2'b11, 4'hC, 4'hA);

        // Reset asserted mid-cycle takes effect immediately
        #2 rst = 1'b0;
        #1;
        chk_out("R1 async", 4'b0000, 2'b00, 4'h0, 4'h0);
        chk("R1 async starve", 32'(starve), 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 4'b0;

        // After release the first grant starts at requester 0
        drive(4'b1111, 2'b01, 1'b0);
        chk("R2 starve", 32'(starve), 32'h0);
        chk_out("R2", 4'b0001, 2'b01, 4'h9, 4'h0);
        drive(4'b1111, 2'b11, 1'b0);
        chk_out("R3", 4'b0110, 2'b11, 4'hA, 4'hB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
